ir_nec_receiver: RTL and testbench
==================================

Name: ir_nec_receiver

Overview:
- Decodes the demodulated IR receiver pin (NEC protocol, active-low) into the 32-bit ir_command word consumed by sensor_driver.
- Sits directly upstream of sensor_driver. ir_command is a held level that changes only when a new valid frame arrives.
- Also flags repeat codes and malformed frames.
- All timing is measured in microseconds, derived from a clk prescaler.

Parameters:
- CLKS_PER_US, 50, clk cycles per microsecond (50 MHz system clock; benches may set 1 for speed).
- TIMEOUT_US, 12000, maximum duration of any single mark or space before the frame is aborted.

Ports:
- clk  input  1  system clock, rising-edge.
- reset_n  input  1  reset; synchronous, active-low.
- ir_rx  input  1  raw IR receiver output, asynchronous, low = carrier present ("mark").
- ir_command  output  32  last valid frame, first received bit in bit 0.
- ir_valid  output  1  one-cycle pulse when ir_command is updated.
- ir_repeat  output  1  one-cycle pulse on a valid repeat code.
- ir_error  output  1  one-cycle pulse on a malformed or aborted frame.

Behaviour:
- Reset: synchronous, active-low, overrides everything. ir_command=0, all pulses 0, FSM=IDLE, counters 0, synchronizer flops loaded 1, has_frame=0.
- Input path: 2-FF synchronizer, then a previous-value register. Fall = mark start; rise = mark end.
- Duration timer: the prescaler counts 0..CLKS_PER_US-1 and increments us_cnt (14-bit), which saturates at 16383. Prescaler and us_cnt clear on every edge. At each edge, us_cnt is the duration of the phase just ended.
- Windows (inclusive, us):
  - lead mark 8000-10000
  - lead space 4000-5000 (data) or 2000-2500 (repeat)
  - bit mark 400-700
  - bit space 400-700 = 0, 1400-1900 = 1
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, REP_MARK.
  - IDLE: on fall -> LEAD_MARK.
  - LEAD_MARK: on rise, if in window -> LEAD_SPACE, else error.
  - LEAD_SPACE: on fall, data window -> BIT_MARK with bit_idx=0; repeat window -> REP_MARK; otherwise error.
  - BIT_MARK: on rise, if in window -> BIT_SPACE, else error. When bit_idx=32, this is the stop burst; rise in window -> frame check.
  - BIT_SPACE: on fall, shift the decoded bit into shift_reg[bit_idx] (LSB first), bit_idx+1 -> BIT_MARK; out of window -> error.
  - REP_MARK: on rise, if in window and has_frame=1 -> pulse ir_repeat. If has_frame=0 -> no pulse and no error. Either case -> IDLE. Out-of-window -> error.
- Frame check: if shift_reg[31:24] == ~shift_reg[23:16], then ir_command <= shift_reg, pulse ir_valid, has_frame <= 1. Otherwise pulse ir_error and leave ir_command unchanged. Address bytes [15:0] are not checked. Both outcomes -> IDLE.
- Error handling: pulse ir_error.
  - Error detected on a fall -> LEAD_MARK (that fall may start a new frame).
  - Error detected on a rise -> IDLE.
- Timeout: in any state except IDLE, when us_cnt reaches TIMEOUT_US -> pulse ir_error once, -> IDLE. Nothing happens in IDLE regardless of duration.
- Latency: ir_valid, ir_repeat and ir_error are registered. They assert on the 3rd rising clk edge after ir_rx changes, counting the sampling edge as 1st. Each pulse is exactly 1 cycle.
- Simultaneity: at most one of ir_valid, ir_repeat, ir_error is high in any cycle. ir_command changes in the same cycle ir_valid is high.
- Glitches: edges inside any window violation are treated as ordinary errors. There is no extra filtering beyond the synchronizer.

Test Plan:
- After reset, drive NEC frame 0xe9166b86 (9 ms/4.5 ms leader, 32 bits LSB-first, 562 us stop). Required: exactly one ir_valid pulse, ir_command=0xe9166b86, ir_error never high.
- Repeat code (9 ms mark, 2.25 ms space, 562 us burst) right after reset: no pulse of any kind. Then send the 0xe9166b86 frame followed by a repeat code: exactly one ir_repeat pulse, ir_command stays 0xe9166b86.
- Frame 0xe9176b86 (inverted command byte mismatch) after a valid 0xe9166b86: one ir_error pulse, no ir_valid, ir_command stays 0xe9166b86.
- Leader mark of 6 ms followed immediately by a proper 0xf30c6b86 frame: one ir_error at the 6 ms rise; the next frame decodes, giving ir_valid and ir_command=0xf30c6b86.
- Frame truncated after 20 bits, then ir_rx held high 15 ms: exactly one ir_error at TIMEOUT_US into the space, FSM back in IDLE. A following 0xed126b86 frame decodes correctly.
- Assert reset_n low for 2 cycles after bit 10 of a frame: all outputs 0 and ir_command=0 on the next edge. A fresh 0xe9166b86 frame afterwards decodes with a single ir_valid pulse.

Source files
------------

// File: rtl/ir_nec_receiver.sv
// NEC infrared frame decoder: measures mark/space widths in microseconds
// and reports data frames, repeat codes and malformed frames.
module ir_nec_receiver #(
    parameter int CLKS_PER_US = 50,
    parameter int TIMEOUT_US  = 12000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ir_rx,
    output logic [31:0] ir_command,
    output logic        ir_valid,
    output logic        ir_repeat,
    output logic        ir_error
);

    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLKS_PER_US - 1);
    localparam logic [13:0] TMO    = 14'(TIMEOUT_US);
    localparam logic [13:0] LM_LO  = 14'd8000;
    localparam logic [13:0] LM_HI  = 14'd10000;
    localparam logic [13:0] LSD_LO = 14'd4000;
    localparam logic [13:0] LSD_HI = 14'd5000;
    localparam logic [13:0] LSR_LO = 14'd2000;
    localparam logic [13:0] LSR_HI = 14'd2500;
    localparam logic [13:0] BM_LO  = 14'd400;
    localparam logic [13:0] BM_HI  = 14'd700;
    localparam logic [13:0] B1_LO  = 14'd1400;
    localparam logic [13:0] B1_HI  = 14'd1900;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_REP_MARK
    } state_t;

    function automatic logic in_win(
        input logic [13:0] v,
        input logic [13:0] lo,
        input logic [13:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

    logic          r_sync1, r_sync2, r_prev;
    logic          w_fall, w_rise, w_edge;
    logic [PW-1:0] r_presc;
    logic [13:0]   r_us;
    state_t        r_state, w_state_nxt;
    logic [5:0]    r_idx, w_idx_nxt;
    logic [31:0]   r_shift, w_shift_nxt;
    logic [31:0]   r_cmd, w_cmd_nxt;
    logic          r_has, w_has_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_rep, w_rep_nxt;
    logic          r_err, w_err_nxt;
    logic          w_lm, w_lsd, w_lsr, w_bm, w_b0, w_b1, w_tmo;

    assign w_fall = r_prev & ~r_sync2;
    assign w_rise = ~r_prev & r_sync2;
    assign w_edge = w_fall | w_rise;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= ir_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // At an edge r_us holds the length of the phase that just ended
    always_ff @(posedge clk) begin
        if (!reset_n || w_edge) begin
            r_presc <= '0;
            r_us    <= '0;
        end else if (r_presc == PMAX) begin
            r_presc <= '0;
            if (r_us != 14'h3FFF) begin
                r_us <= r_us + 14'd1;
            end
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    assign w_lm  = in_win(r_us, LM_LO, LM_HI);
    assign w_lsd = in_win(r_us, LSD_LO, LSD_HI);
    assign w_lsr = in_win(r_us, LSR_LO, LSR_HI);
    assign w_bm  = in_win(r_us, BM_LO, BM_HI);
    assign w_b0  = w_bm;
    assign w_b1  = in_win(r_us, B1_LO, B1_HI);
    assign w_tmo = (r_us >= TMO);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_cmd_nxt   = r_cmd;
        w_has_nxt   = r_has;
        w_valid_nxt = 1'b0;
        w_rep_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        if (r_state != S_IDLE && !w_edge && w_tmo) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_fall) w_state_nxt = S_LEAD_MARK;
                end
                S_LEAD_MARK: begin
                    if (w_rise) begin
                        if (w_lm) begin
                            w_state_nxt = S_LEAD_SPACE;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                S_LEAD_SPACE: begin
                    if (w_fall) begin
                        if (w_lsd) begin
                            w_idx_nxt   = 6'd0;
                            w_state_nxt = S_BIT_MARK;
                        end else if (w_lsr) begin
                            w_state_nxt = S_REP_MARK;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_LEAD_MARK;
                        end
                    end
                end
                S_BIT_MARK: begin
                    if (w_rise) begin
                        if (!w_bm) begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else if (r_idx == 6'd32) begin
                            // Stop burst: command byte must match its complement
                            if (r_shift[31:24] == ~r_shift[23:16]) begin
                                w_cmd_nxt   = r_shift;
                                w_valid_nxt = 1'b1;
                                w_has_nxt   = 1'b1;
                            end else begin
                                w_err_nxt = 1'b1;
                            end
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_BIT_SPACE;
                        end
                    end
                end
                S_BIT_SPACE: begin
                    if (w_fall) begin
                        if (w_b0 || w_b1) begin
                            w_shift_nxt[r_idx[4:0]] = w_b1;
                            w_idx_nxt   = r_idx + 6'd1;
                            w_state_nxt = S_BIT_MARK;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = S_LEAD_MARK;
                        end
                    end
                end
                S_REP_MARK: begin
                    if (w_rise) begin
                        if (w_bm) begin
                            w_rep_nxt = r_has;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_shift <= '0;
            r_cmd   <= '0;
            r_has   <= 1'b0;
            r_valid <= 1'b0;
            r_rep   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_cmd   <= w_cmd_nxt;
            r_has   <= w_has_nxt;
            r_valid <= w_valid_nxt;
            r_rep   <= w_rep_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign ir_command = r_cmd;
    assign ir_valid   = r_valid;
    assign ir_repeat  = r_rep;
    assign ir_error   = r_err;

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Directed bench for ir_nec_receiver: NEC frames, repeat codes, bad frames,
// timeout and mid-frame reset, one microsecond per clock.
module tb_ir_nec_receiver;

    localparam int CPU = 1;
    localparam int TMO = 12000;

    localparam int K_REP   = 0;
    localparam int K_FRAME = 1;
    localparam int K_SHORT = 2;
    localparam int K_TRUNC = 3;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] data;
        int          exp_val;
        int          exp_rep;
        int          exp_err;
        logic [31:0] exp_cmd;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ir_rx = 1'b1;
    logic [31:0] ir_command;
    logic        ir_valid;
    logic        ir_repeat;
    logic        ir_error;

    int          checks = 0;
    int          failures = 0;
    int          n_val = 0;
    int          n_rep = 0;
    int          n_err = 0;
    logic [31:0] prev_cmd = '0;

    ir_nec_receiver #(
        .CLKS_PER_US(CPU),
        .TIMEOUT_US (TMO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ir_rx     (ir_rx),
        .ir_command(ir_command),
        .ir_valid  (ir_valid),
        .ir_repeat (ir_repeat),
        .ir_error  (ir_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n) begin
            n_val += int'(ir_valid);
            n_rep += int'(ir_repeat);
            n_err += int'(ir_error);
            if (ir_valid || ir_repeat || ir_error) begin
                checks++;
                if (int'(ir_valid) + int'(ir_repeat) + int'(ir_error) > 1) begin
                    failures++;
                    $display("FAIL onehot: v=%b r=%b e=%b required at most one",
                             ir_valid, ir_repeat, ir_error);
                end
            end
            if (ir_command !== prev_cmd) begin
                checks++;
                if (ir_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL cmd_change: %h -> %h without ir_valid",
                             prev_cmd, ir_command);
                end
            end
        end
        prev_cmd = ir_command;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int us);
        ir_rx = lvl;
        repeat (us * CPU) @(negedge clk);
    endtask

    task automatic send_head(input logic [31:0] d, input int n);
        hold(1'b0, 9000);
        hold(1'b1, 4500);
        for (int i = 0; i < n; i++) begin
            hold(1'b0, 562);
            hold(1'b1, d[i] ? 1687 : 562);
        end
    endtask

    task automatic send_frame(input logic [31:0] d);
        send_head(d, 32);
        hold(1'b0, 562);
        hold(1'b1, 3000);
    endtask

    task automatic send_rep();
        hold(1'b0, 9000);
        hold(1'b1, 2250);
        hold(1'b0, 562);
        hold(1'b1, 3000);
    endtask

    vec_t tbl[7];

    initial begin
        int bv, br, be;
        tbl[0] = '{"rep_no_frame", K_REP,   32'h0,        0, 0, 0, 32'h0};
        tbl[1] = '{"frame_a",      K_FRAME, 32'hE9166B86, 1, 0, 0, 32'hE9166B86};
        tbl[2] = '{"rep_after_a",  K_REP,   32'h0,        0, 1, 0, 32'hE9166B86};
        tbl[3] = '{"bad_inv",      K_FRAME, 32'hE9176B86, 0, 0, 1, 32'hE9166B86};
        tbl[4] = '{"short_lead",   K_SHORT, 32'hF30C6B86, 1, 0, 1, 32'hF30C6B86};
        tbl[5] = '{"trunc_tmo",    K_TRUNC, 32'hED126B86, 0, 0, 1, 32'hF30C6B86};
        tbl[6] = '{"frame_ed",     K_FRAME, 32'hED126B86, 1, 0, 0, 32'hED126B86};

        reset_n = 1'b0;
        ir_rx   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cmd", ir_command, 32'h0);
        check("rst_valid", 32'(ir_valid), 32'h0);
        check("rst_repeat", 32'(ir_repeat), 32'h0);
        check("rst_error", 32'(ir_error), 32'h0);
        reset_n = 1'b1;
        hold(1'b1, 100);

        for (int k = 0; k < 7; k++) begin
            bv = n_val;
            br = n_rep;
            be = n_err;
            case (tbl[k].kind)
                K_REP:   send_rep();
                K_FRAME: send_frame(tbl[k].data);
                K_SHORT: begin
                    hold(1'b0, 6000);
                    hold(1'b1, 500);
                    send_frame(tbl[k].data);
                end
                default: begin
                    send_head(tbl[k].data, 19);
                    hold(1'b0, 562);
                    hold(1'b1, 11500);
                    check({tbl[k].name, "_early"}, 32'(n_err - be), 32'h0);
                    hold(1'b1, 3500);
                end
            endcase
            check({tbl[k].name, "_valid"}, 32'(n_val - bv), 32'(tbl[k].exp_val));
            check({tbl[k].name, "_repeat"}, 32'(n_rep - br), 32'(tbl[k].exp_rep));
            check({tbl[k].name, "_error"}, 32'(n_err - be), 32'(tbl[k].exp_err));
            check({tbl[k].name, "_cmd"}, ir_command, tbl[k].exp_cmd);
        end

        send_head(32'hE9166B86, 10);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_cmd", ir_command, 32'h0);
        check("midrst_pulses", {29'h0, ir_valid, ir_repeat, ir_error}, 32'h0);
        reset_n = 1'b1;
        hold(1'b1, 3000);

        bv = n_val;
        be = n_err;
        send_head(32'hE9166B86, 32);
        hold(1'b0, 562);
        ir_rx = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("lat_edge2", 32'(ir_valid), 32'h0);
        @(negedge clk);
        check("lat_edge3", 32'(ir_valid), 32'h1);
        check("lat_cmd", ir_command, 32'hE9166B86);
        @(negedge clk);
        check("lat_width", 32'(ir_valid), 32'h0);
        hold(1'b1, 2000);
        check("post_rst_valid", 32'(n_val - bv), 32'h1);
        check("post_rst_error", 32'(n_err - be), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
